// File: rtl/ofmap_writer.sv
// Streams conv output words into the output SRAM, overwriting or accumulating with signed saturation.
// Overwrite: one word per cycle, write lands on the accept edge. Accumulate: read then write, 2 cycles per word.
// Backpressure: data_ready_o is low in RD while the read is issued; the word is consumed in ACC.

`ifndef WRITE_ENB
`define WRITE_ENB 4'b0000
`endif
`ifndef WRITE_DIS
`define WRITE_DIS 4'b1111
`endif

module ofmap_writer #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              acc_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              data_ready_o,
    output logic              busy_o,
    output logic              finish_o,
    output logic              cs,
    output logic              oe,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        W_req,
    output logic [DATA_W-1:0] W_data,
    input  logic [DATA_W-1:0] R_data
);

    typedef enum logic [2:0] {IDLE, WR, RD, ACC, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [LEN_W-1:0]    remaining;
    logic [DATA_W-1:0]   hold_q;
    logic [DATA_W:0]     wide_sum;
    logic [DATA_W-1:0]   sat_sum;
    logic                in_job;

    // One guard bit is enough to detect signed overflow of the partial-sum update.
    assign wide_sum = {R_data[DATA_W-1], R_data} + {hold_q[DATA_W-1], hold_q};

    always_comb begin
        sat_sum = wide_sum[DATA_W-1:0];
        if (wide_sum[DATA_W] != wide_sum[DATA_W-1]) begin
            sat_sum = wide_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign in_job = (state == WR) || (state == RD) || (state == ACC);

    // Bus strobes follow the stream valid in the same cycle, so they are decoded here.
    always_comb begin
        cs     = 1'b0;
        oe     = 1'b0;
        addr   = '0;
        W_req  = `WRITE_DIS;
        W_data = '0;
        if (in_job) begin
            addr = ptr;
        end
        case (state)
            WR: begin
                cs     = 1'b1;
                W_data = data_i;
                if (data_valid_i) begin
                    W_req = `WRITE_ENB;
                end
            end
            RD: begin
                cs = data_valid_i;
                oe = data_valid_i;
            end
            ACC: begin
                cs     = 1'b1;
                W_data = sat_sum;
                W_req  = `WRITE_ENB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            remaining    <= '0;
            hold_q       <= '0;
            data_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            finish_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !finish_o) begin
                        ptr       <= base_addr_i;
                        remaining <= len_i;
                        if (len_i == '0) begin
                            state    <= DONE;
                            finish_o <= 1'b1;
                        end else if (!acc_i) begin
                            state        <= WR;
                            busy_o       <= 1'b1;
                            data_ready_o <= 1'b1;
                        end else begin
                            state  <= RD;
                            busy_o <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (data_valid_i) begin
                        ptr       <= ptr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state        <= DONE;
                            busy_o       <= 1'b0;
                            data_ready_o <= 1'b0;
                            finish_o     <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (data_valid_i) begin
                        hold_q       <= data_i;
                        state        <= ACC;
                        data_ready_o <= 1'b1;
                    end
                end
                ACC: begin
                    ptr          <= ptr + ADDR_W'(1);
                    remaining    <= remaining - LEN_W'(1);
                    data_ready_o <= 1'b0;
                    if (remaining == LEN_W'(1)) begin
                        state    <= DONE;
                        busy_o   <= 1'b0;
                        finish_o <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                DONE: begin
                    // Requester must drop start before ownership of the buffer is handed back.
                    if (!start_i) begin
                        state    <= IDLE;
                        finish_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
